// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S master clock generator.
//   i2s_state_e    : sequencer states (IDLE, RUN, DRAIN)
//   I2S_WIDTH_DEF  : default bits per channel slot
//   DIV_W_DEF      : default width of the sclk half-period divider value
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } i2s_state_e;

  localparam int I2S_WIDTH_DEF = 16;
  localparam int DIV_W_DEF     = 8;

endpackage

// File: rtl/i2s_sclk_div.sv
// sclk divider: counts clk cycles 0..D-1 and toggles sclk on every wrap.
// Ports:
//   clk, rst    : system clock, async active-high reset
//   load        : latch d (0 is treated as 1) and restart from sclk=0
//   d           : half-period in clk cycles
//   run         : keep generating; when low sclk is forced to 0
//   sclk        : registered bit clock
//   rise, fall  : registered one-cycle strobes coinciding with sclk edges
//   fall_next   : combinational, the coming clk edge produces a falling sclk
module i2s_sclk_div
  import i2s_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] d,
  input  logic             run,
  output logic             sclk,
  output logic             rise,
  output logic             fall,
  output logic             fall_next
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             wrap;

  assign wrap      = (cnt_q == (div_q - DIV_W'(1)));
  // sclk is held 0 while stopped, so this can only fire while running.
  assign fall_next = wrap & sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_W'(1);
      cnt_q <= '0;
      sclk  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (load) begin
        div_q <= (d == '0) ? DIV_W'(1) : d;
        cnt_q <= '0;
        sclk  <= 1'b0;
      end else if (!run) begin
        // Covers the final falling edge on drain exit: sclk returns low
        // without a fall strobe, so no strobe is ever visible in IDLE.
        cnt_q <= '0;
        sclk  <= 1'b0;
      end else if (wrap) begin
        cnt_q <= '0;
        sclk  <= ~sclk;
        rise  <= ~sclk;
        fall  <= sclk;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_clk_master.sv
// Master-mode I2S timing generator: produces sclk/ws plus system-clock
// aligned edge and frame strobes; starts and stops on frame boundaries.
// Ports:
//   clk_i, rst_i  : system clock, async active-high reset
//   start_i       : request to begin streaming (accepted only in IDLE)
//   stop_i        : request to stop at the end of the current frame
//   divHalf_i     : sclk half-period in clk_i cycles, latched on start
//   sclk_o, ws_o  : I2S bit clock and word select (0 = left, 1 = right)
//   sclkRise_o    : strobe in the cycle sclk_o goes 0->1
//   sclkFall_o    : strobe in the cycle sclk_o goes 1->0
//   frameStart_o  : strobe when ws_o enters the left slot of a new frame
//   busy_o        : high in RUN or DRAIN
//
// state | meaning
// IDLE  | sclk low, ws high, waiting for start_i
// RUN   | generating frames
// DRAIN | stop requested; finishing the current frame
module i2s_clk_master
  import i2s_pkg::*;
#(
  parameter int WIDTH = I2S_WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] divHalf_i,
  output logic             sclk_o,
  output logic             ws_o,
  output logic             sclkRise_o,
  output logic             sclkFall_o,
  output logic             frameStart_o,
  output logic             busy_o
);

  localparam int              BIT_W     = $clog2(2 * WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(2 * WIDTH - 1);
  localparam logic [BIT_W-1:0] RIGHT_BIT = BIT_W'(WIDTH);

  i2s_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [BIT_W-1:0] bit_cnt_nxt;
  logic             load;
  logic             run;
  logic             fall_next;
  logic             frame_end;

  assign frame_end   = fall_next && (bit_cnt_q == LAST_BIT);
  assign bit_cnt_nxt = frame_end ? '0 : bit_cnt_q + BIT_W'(1);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (stop_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (frame_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign run = (state_d != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q    <= '0;
      ws_o         <= 1'b1;
      frameStart_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      frameStart_o <= 1'b0;
      if (load) begin
        // Entry acts as a virtual falling edge opening the left slot.
        bit_cnt_q    <= '0;
        ws_o         <= 1'b0;
        busy_o       <= 1'b1;
        frameStart_o <= 1'b1;
      end else if ((state_q != IDLE) && !run) begin
        bit_cnt_q <= '0;
        ws_o      <= 1'b1;
        busy_o    <= 1'b0;
      end else if (fall_next) begin
        bit_cnt_q <= bit_cnt_nxt;
        if (bit_cnt_nxt == '0) begin
          ws_o         <= 1'b0;
          frameStart_o <= 1'b1;
        end else if (bit_cnt_nxt == RIGHT_BIT) begin
          ws_o <= 1'b1;
        end
      end
    end
  end

  i2s_sclk_div #(
    .DIV_W(DIV_W)
  ) u_sclk_div (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (load),
    .d        (divHalf_i),
    .run      (run),
    .sclk     (sclk_o),
    .rise     (sclkRise_o),
    .fall     (sclkFall_o),
    .fall_next(fall_next)
  );

endmodule
